// File: rtl/std_sram_singleport_ctrl.sv
// Single-port SRAM front end: zero-fills the whole array after reset or clr,
// then serves one read or write per cycle with a registered, backpressured read response.
//   state | meaning
//   INIT  | sweeping every address with zero, requests blocked
//   RUN   | accepting requests, init_done high
module std_sram_singleport_ctrl #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  init_done
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;
    logic                  rd_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = cnt;
        sram_din  = '0;
        case (state)
            INIT: begin
                sram_en = 1'b1;
                sram_we = 1'b1;
                // cnt wraps back to zero on the last address, ready for a later clr
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                req_ready = ~clr & (~resp_valid | resp_ready);
                sram_en   = req_valid & req_ready;
                sram_we   = req_we;
                sram_addr = req_addr;
                sram_din  = req_wdata;
                if (clr) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign rd_accept = (state == RUN) & req_valid & req_ready & ~req_we;

    // A pending response survives clr; only reset or consumption drops it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else if (rd_accept) begin
            resp_valid <= 1'b1;
            resp_rdata <= sram_dout;
        end else if (resp_valid & resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    assign init_done = (state == RUN);

endmodule

// File: tb/tb_std_sram_singleport_ctrl.sv
// Bench for std_sram_singleport_ctrl: behavioural SRAM plus an array/flag reference
// model, directed scenarios followed by randomized traffic.
module tb_std_sram_singleport_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          clr;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;
    logic          init_done;

    std_sram_singleport_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // behavioural single-port SRAM, combinational read
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (sram_en && sram_we) sram_mem[sram_addr] <= sram_din;
    end
    assign sram_dout = sram_mem[sram_addr];

    // reference model
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_run;
    int            m_left;
    bit            m_valid;
    logic [DW-1:0] m_data;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear_mem();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    // Called at a negedge right after the controller entered INIT with the count at zero.
    task automatic check_init_seq();
        req_valid = 1'b0;
        clr       = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("init_en",    sram_en,   1);
            check("init_we",    sram_we,   1);
            check("init_addr",  sram_addr, i);
            check("init_din",   sram_din,  0);
            check("init_done0", init_done, 0);
            check("init_ready", req_ready, 0);
            @(negedge clk);
        end
        #1 check("init_done1", init_done, 1);
        model_clear_mem();
        m_run  = 1'b1;
        m_left = 0;
    endtask

    // One clock cycle of stimulus; entered and left at a negedge.
    task automatic step(input bit v, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit rr, input bit c);
        bit ready;
        req_valid  = v;
        req_we     = we;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = rr;
        clr        = c;
        ready = m_run && !c && (!m_valid || rr);
        #1;
        check("req_ready", req_ready, ready);
        check("init_done", init_done, m_run);
        if (ready && v && we) m_mem[a] = d;
        if (ready && v && !we) begin
            m_valid = 1'b1;
            m_data  = m_mem[a];
        end else if (m_valid && rr) begin
            m_valid = 1'b0;
        end
        if (m_run && c) begin
            m_run  = 1'b0;
            m_left = DEPTH;
            model_clear_mem();
        end else if (!m_run) begin
            m_left--;
            if (m_left == 0) m_run = 1'b1;
        end
        @(negedge clk);
        check("resp_valid", resp_valid, m_valid);
        if (m_valid) check("resp_rdata", resp_rdata, m_data);
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = DW'($urandom);
        m_run = 1'b0; m_left = 0; m_valid = 1'b0; m_data = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_init_done",  init_done,  0);
        check("rst_req_ready",  req_ready,  0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        @(negedge clk);
        reset = 1'b0;
        check_init_seq();

        // every address reads back zero after the clear sweep
        for (int i = 0; i < DEPTH; i++) step(1, 0, AW'(i), 8'h00, 1, 0);
        check("clear_readback", resp_rdata, 0);

        // write then immediate read of the same address
        step(1, 1, 4'd3, 8'hA5, 1, 0);
        step(1, 0, 4'd3, 8'h00, 1, 0);
        check("wr_rd_3", resp_rdata, 8'hA5);
        step(0, 0, 4'd0, 8'h00, 1, 0);

        // back-to-back reads
        step(1, 1, 4'd1, 8'h11, 1, 0);
        step(1, 1, 4'd2, 8'h22, 1, 0);
        step(1, 1, 4'd3, 8'h33, 1, 0);
        step(1, 0, 4'd1, 8'h00, 1, 0);
        check("b2b_1", resp_rdata, 8'h11);
        step(1, 0, 4'd2, 8'h00, 1, 0);
        check("b2b_2", resp_rdata, 8'h22);
        step(1, 0, 4'd3, 8'h00, 1, 0);
        check("b2b_3", resp_rdata, 8'h33);
        step(0, 0, 4'd0, 8'h00, 1, 0);

        // backpressure on a pending read
        step(1, 1, 4'd5, 8'h5E, 1, 0);
        step(1, 0, 4'd5, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 4'd6, 8'h00, 0, 0);
        check("bp_hold", resp_rdata, 8'h5E);
        step(0, 0, 4'd0, 8'h00, 1, 0);

        // clr forces a fresh clear sweep
        step(1, 1, 4'd7, 8'h3C, 1, 0);
        step(0, 0, 4'd0, 8'h00, 1, 1);
        check_init_seq();
        step(1, 0, 4'd7, 8'h00, 1, 0);
        check("clr_rd_7", resp_rdata, 8'h00);
        step(0, 0, 4'd0, 8'h00, 1, 0);

        // reset in the middle of a clear sweep with a response still pending
        step(1, 1, 4'd9, 8'h99, 1, 0);
        step(1, 0, 4'd9, 8'h00, 0, 0);
        step(0, 0, 4'd0, 8'h00, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 4'd0, 8'h00, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_init_done",  init_done,  0);
        check("midrst_rdata",      resp_rdata, 0);
        check("midrst_addr",       sram_addr,  0);
        @(negedge clk);
        reset = 1'b0;
        m_valid = 1'b0; m_data = '0;
        check_init_seq();

        // randomized traffic with occasional clr
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 AW'($urandom), DW'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
